// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response codes, size encoding and read FSM states
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } rd_state_t;

endpackage

// File: rtl/sync_word_ram.sv
// rtl/sync_word_ram.sv - DEPTH x 32 word memory, one write port, one registered read port
module sync_word_ram #(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = "",
  parameter int    AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Read output only moves when re_i is set, so a stalled reader sees stable data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - single-burst AXI read slave over a preloadable word memory
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter int    LAT       = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int AW = $clog2(DEPTH);

  rd_state_t   state_q;
  logic [30:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [3:0]  lat_q;
  logic        err_size_q;
  logic        arready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [1:0]  rresp_q;

  logic          ar_hs;
  logic          r_hs;
  logic [30:0]   addr_inc;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;
  logic          unused_addr_lsbs;

  assign ar_hs            = arready_q & arvalid;
  assign r_hs             = rvalid_q & rready;
  assign addr_inc         = addr_q + 31'd1;
  assign unused_addr_lsbs = ^araddr[1:0];

  // The 31-bit address never wraps, so anything past DEPTH (including 2^30) is an error.
  function automatic logic [1:0] beat_resp(input logic err_size, input logic [30:0] a);
    return (err_size || (a >= 31'(DEPTH))) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  always_comb begin
    ram_re    = (state_q == WAIT) | r_hs;
    ram_raddr = r_hs ? addr_inc[AW-1:0] : addr_q[AW-1:0];
  end

  sync_word_ram #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ld_en & (state_q == IDLE)),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      err_size_q <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            addr_q     <= {1'b0, araddr[31:2]};
            len_q      <= arlen;
            err_size_q <= (arsize != SIZE_WORD);
            lat_q      <= 4'(LAT);
            beat_q     <= '0;
            arready_q  <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == 4'd0) begin
            state_q  <= BURST;
            rvalid_q <= 1'b1;
            rlast_q  <= (len_q == 8'd0);
            rresp_q  <= beat_resp(err_size_q, addr_q);
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q   <= IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= RESP_OKAY;
              arready_q <= 1'b1;
            end else begin
              beat_q  <= beat_q + 8'd1;
              addr_q  <= addr_inc;
              rlast_q <= ((beat_q + 8'd1) == len_q);
              rresp_q <= beat_resp(err_size_q, addr_inc);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - directed vector bench for axi_rd_responder
module tb_axi_rd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  int checks = 0;
  int errors = 0;

  axi_rd_responder #(.DEPTH(4096), .LAT(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [7:0]  rr;
    logic        ld_same;
    logic [31:0] exp_data [8];
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int k;
    int beat;
    int first_seen;
    bit done;
    bit stalled;
    logic [31:0] prev_data;
    logic [1:0]  prev_resp;
    logic        prev_last;
    @(negedge clk);
    chk($sformatf("v%0d arready_idle", i), {31'd0, arready}, 32'd1);
    araddr = vecs[i].araddr; arlen = vecs[i].arlen; arsize = vecs[i].arsize; arvalid = 1'b1;
    if (vecs[i].ld_same) begin
      ld_en = 1'b1; ld_addr = vecs[i].araddr[13:2]; ld_data = vecs[i].exp_data[0];
    end
    @(posedge clk);
    #1 arvalid = 1'b0; ld_en = 1'b0;
    beat = 0; first_seen = -1; done = 0; stalled = 0;
    prev_data = '0; prev_resp = '0; prev_last = 1'b0;
    for (k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      ld_en = (k == 1); ld_addr = 12'd9; ld_data = 32'h00000BAD;
      chk($sformatf("v%0d arready_busy k%0d", i, k), {31'd0, arready}, 32'd0);
      if (stalled) begin
        chk($sformatf("v%0d hold_valid", i), {31'd0, rvalid}, 32'd1);
        chk($sformatf("v%0d hold_data", i), rdata, prev_data);
        chk($sformatf("v%0d hold_resp", i), {30'd0, rresp}, {30'd0, prev_resp});
        chk($sformatf("v%0d hold_last", i), {31'd0, rlast}, {31'd0, prev_last});
      end
      if (rvalid && first_seen < 0) first_seen = k;
      rready = vecs[i].rr[k & 7];
      if (rvalid && rready) begin
        chk($sformatf("v%0d b%0d data", i, beat), rdata, vecs[i].exp_data[beat]);
        chk($sformatf("v%0d b%0d resp", i, beat), {30'd0, rresp},
            vecs[i].exp_err[beat] ? 32'd2 : 32'd0);
        chk($sformatf("v%0d b%0d last", i, beat), {31'd0, rlast},
            (beat == int'(vecs[i].arlen)) ? 32'd1 : 32'd0);
        beat++;
        if (beat == int'(vecs[i].arlen) + 1) done = 1;
      end
      stalled = rvalid && !rready;
      prev_data = rdata; prev_resp = rresp; prev_last = rlast;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL v%0d timeout: got %0d beats expected %0d", i, beat, int'(vecs[i].arlen) + 1);
    end
    chk($sformatf("v%0d latency", i), first_seen, 32'd3);
    @(negedge clk);
    ld_en = 1'b0; rready = 1'b0;
    chk($sformatf("v%0d arready_after", i), {31'd0, arready}, 32'd1);
    chk($sformatf("v%0d rvalid_after", i), {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    int beats;
    vecs[0] = '{32'h10, 8'd0, 3'd2, 8'hFF, 1'b0,
                '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0}, 8'h00};
    vecs[1] = '{32'h20, 8'd7, 3'd2, 8'hFF, 1'b0,
                '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107}, 8'h00};
    vecs[2] = '{32'h20, 8'd7, 3'd2, 8'b1001_1001, 1'b0,
                '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107}, 8'h00};
    vecs[3] = '{32'h3FF8, 8'd3, 3'd2, 8'hFF, 1'b0,
                '{32'hAAAA0001, 32'hAAAA0002, 0, 0, 0, 0, 0, 0}, 8'b0000_1100};
    vecs[4] = '{32'h20, 8'd1, 3'd0, 8'hFF, 1'b0,
                '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0011};
    vecs[5] = '{32'h14, 8'd0, 3'd2, 8'hFF, 1'b1,
                '{32'h00005555, 0, 0, 0, 0, 0, 0, 0}, 8'h00};

    #12;
    chk("reset arready", {31'd0, arready}, 32'd0);
    chk("reset rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset rlast", {31'd0, rlast}, 32'd0);
    chk("reset rresp", {30'd0, rresp}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arready_rise", {31'd0, arready}, 32'd1);

    load(12'd4, 32'hDEADBEEF);
    for (int j = 0; j < 8; j++) load(12'(8 + j), 32'h100 + 32'(j));
    load(12'd4094, 32'hAAAA0001);
    load(12'd4095, 32'hAAAA0002);

    for (int i = 0; i < 6; i++) run_vec(i);

    @(negedge clk);
    araddr = 32'h20; arlen = 8'd7; arsize = 3'd2; arvalid = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0; rready = 1'b1;
    beats = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rvalid && beats == 3) break;
      if (rvalid) beats++;
    end
    chk("rst_mid beat_reached", beats, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_mid rlast", {31'd0, rlast}, 32'd0);
    chk("rst_mid rdata", rdata, 32'd0);
    chk("rst_mid arready", {31'd0, arready}, 32'd0);
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid arready_after", {31'd0, arready}, 32'd1);
    chk("rst_mid rvalid_after", {31'd0, rvalid}, 32'd0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
